// File: rtl/midi_burst_gen.sv
// MIDI Note On/Off parser, voice table and rate-limited snapshot publisher.
// Optional VOICE_STEAL_EN: a full table replaces its oldest voice instead of dropping.
module midi_burst_gen #(
    parameter int NUM_VOICES     = 5,
    parameter int MIDI_CHANNEL   = 0,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [7:0]                 midi_byte_in,
    input  logic                       midi_byte_valid_in,
    output logic [16*NUM_VOICES-1:0]   midi_burst_data_out,
    output logic [NUM_VOICES-1:0]      on_array_out,
    output logic                       midi_burst_change_out,
    output logic                       voice_drop_out,
    output logic [1:0]                 parser_state_out
);

    localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [3:0] CH = 4'(MIDI_CHANNEL);
    localparam logic [AW-1:0] AMAX = AW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        WAIT_STATUS = 2'd0,
        WAIT_NOTE   = 2'd1,
        WAIT_VEL    = 2'd2,
        IGNORE      = 2'd3
    } pstate_t;

    pstate_t               state;
    logic                  note_on_q;
    logic [6:0]            note_q;
    logic [6:0]            tbl_note [NUM_VOICES];
    logic [6:0]            tbl_vel  [NUM_VOICES];
    logic [AW-1:0]         tbl_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] tbl_on;
    logic                  pending;
    logic [HW-1:0]         holdoff;

    logic [6:0]            nx_note [NUM_VOICES];
    logic [6:0]            nx_vel  [NUM_VOICES];
    logic [AW-1:0]         nx_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] nx_on;
    logic                  changed, drop;
    logic                  is_rt, is_note_status, exec, key_on;
    logic                  hit, free, alloc;
    logic [AW-1:0]         hit_idx, free_idx, tgt;
`ifdef VOICE_STEAL_EN
    logic [AW-1:0]         old_idx, old_age;
`endif

    assign parser_state_out = state;

    always_comb begin
        is_rt          = midi_byte_in >= 8'hF8;
        is_note_status = (midi_byte_in[7:5] == 3'b100) && (midi_byte_in[3:0] == CH);
        exec           = midi_byte_valid_in && !midi_byte_in[7] && (state == WAIT_VEL);
        key_on         = note_on_q && (midi_byte_in[6:0] != 7'd0);
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
`ifdef VOICE_STEAL_EN
        old_idx  = '0;
        old_age  = '0;
`endif
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!hit && tbl_on[i] && tbl_note[i] == note_q) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
            if (!free && !tbl_on[i]) begin
                free     = 1'b1;
                free_idx = AW'(i);
            end
`ifdef VOICE_STEAL_EN
            // Strict compare keeps the lowest index on an age tie.
            if (tbl_age[i] > old_age) begin
                old_age = tbl_age[i];
                old_idx = AW'(i);
            end
`endif
        end

        nx_note = tbl_note;
        nx_vel  = tbl_vel;
        nx_age  = tbl_age;
        nx_on   = tbl_on;
        changed = 1'b0;
        drop    = 1'b0;
        alloc   = 1'b0;
        tgt     = '0;
        if (exec && key_on) begin
            if (hit) begin
                nx_vel[hit_idx] = midi_byte_in[6:0];
                changed         = 1'b1;
            end else if (free) begin
                alloc = 1'b1;
                tgt   = free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                alloc = 1'b1;
                tgt   = old_idx;
`else
                drop  = 1'b1;
`endif
            end
        end else if (exec && hit) begin
            nx_note[hit_idx] = '0;
            nx_vel[hit_idx]  = '0;
            nx_age[hit_idx]  = '0;
            nx_on[hit_idx]   = 1'b0;
            changed          = 1'b1;
        end
        if (alloc) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (nx_on[i] && AW'(i) != tgt && nx_age[i] != AMAX)
                    nx_age[i] = nx_age[i] + 1'b1;
            end
            nx_note[tgt] = note_q;
            nx_vel[tgt]  = midi_byte_in[6:0];
            nx_age[tgt]  = '0;
            nx_on[tgt]   = 1'b1;
            changed      = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state                 <= WAIT_STATUS;
            note_on_q             <= 1'b0;
            note_q                <= '0;
            tbl_on                <= '0;
            pending               <= 1'b0;
            holdoff               <= '0;
            midi_burst_data_out   <= '0;
            on_array_out          <= '0;
            midi_burst_change_out <= 1'b0;
            voice_drop_out        <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                tbl_note[i] <= '0;
                tbl_vel[i]  <= '0;
                tbl_age[i]  <= '0;
            end
        end else begin
            if (midi_byte_valid_in && !is_rt) begin
                if (midi_byte_in[7]) begin
                    if (is_note_status) begin
                        note_on_q <= midi_byte_in[4];
                        state     <= WAIT_NOTE;
                    end else begin
                        state <= IGNORE;
                    end
                end else begin
                    case (state)
                        WAIT_NOTE: begin
                            note_q <= midi_byte_in[6:0];
                            state  <= WAIT_VEL;
                        end
                        WAIT_VEL: state <= WAIT_NOTE;
                        default: ;
                    endcase
                end
            end
            tbl_note       <= nx_note;
            tbl_vel        <= nx_vel;
            tbl_age        <= nx_age;
            tbl_on         <= nx_on;
            voice_drop_out <= drop;
            midi_burst_change_out <= 1'b0;
            if (holdoff != '0)
                holdoff <= holdoff - 1'b1;
            // Publish the pre-update table; a same-cycle change re-arms pending.
            if (pending && holdoff == '0) begin
                for (int i = 0; i < NUM_VOICES; i++)
                    midi_burst_data_out[16*i +: 16] <= {1'b0, tbl_note[i], 1'b0, tbl_vel[i]};
                on_array_out          <= tbl_on;
                midi_burst_change_out <= 1'b1;
                holdoff               <= HW'(HOLDOFF_CYCLES - 1);
                pending               <= changed;
            end else if (changed) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_midi_burst_gen.sv
// Bench for midi_burst_gen: directed scenarios plus random byte streams
// compared cycle by cycle against a voice-list model.
module tb_midi_burst_gen;
    localparam int NV = 5;
    localparam int CH = 0;
    localparam int H  = 64;

    logic               clk_in = 1'b0;
    logic               rst_n_in = 1'b0;
    logic [7:0]         midi_byte_in = 8'h00;
    logic               midi_byte_valid_in = 1'b0;
    logic [16*NV-1:0]   midi_burst_data_out;
    logic [NV-1:0]      on_array_out;
    logic               midi_burst_change_out;
    logic               voice_drop_out;
    logic [1:0]         parser_state_out;

    midi_burst_gen #(.NUM_VOICES(NV), .MIDI_CHANNEL(CH), .HOLDOFF_CYCLES(H)) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .midi_byte_in(midi_byte_in),
        .midi_byte_valid_in(midi_byte_valid_in),
        .midi_burst_data_out(midi_burst_data_out),
        .on_array_out(on_array_out),
        .midi_burst_change_out(midi_burst_change_out),
        .voice_drop_out(voice_drop_out),
        .parser_state_out(parser_state_out)
    );

    always #5 clk_in = ~clk_in;

    int passed = 0;
    int total = 0;

    // Model: voice list with allocation stamps, parser position, publish time.
    int  m_note [NV];
    int  m_vel [NV];
    int  m_stamp [NV];
    bit  m_on [NV];
    int  m_allocs, ps, m_cur;
    bit  m_is_on, m_pend;
    int  ecyc, last_pub;
    logic [16*NV-1:0] exp_data;
    logic [NV-1:0]    exp_on;
    logic exp_chg, exp_drop;
    int  pulses, drops, exp_pulses, exp_drops, mm;
    string mm_what;
    logic [79:0] mm_obs, mm_exp;

    function automatic logic [16*NV-1:0] snap_data();
        logic [16*NV-1:0] r = '0;
        for (int i = 0; i < NV; i++) begin
            int n = m_note[i];
            int v = m_vel[i];
            if (m_on[i]) r[16*i +: 16] = {n[7:0], v[7:0]};
        end
        return r;
    endfunction

    function automatic logic [NV-1:0] snap_on();
        logic [NV-1:0] r = '0;
        for (int i = 0; i < NV; i++) r[i] = m_on[i];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = 0; m_vel[i] = 0; m_stamp[i] = 0; m_on[i] = 0;
        end
        m_allocs = 0; ps = 0; m_cur = 0; m_is_on = 0; m_pend = 0;
        ecyc = 0; last_pub = -1000000;
        exp_data = '0; exp_on = '0; exp_chg = 0; exp_drop = 0;
        pulses = 0; drops = 0; exp_pulses = 0; exp_drops = 0; mm = 0;
    endtask

    task automatic m_apply(input bit on, input int n, input int v);
        int k = -1;
        int best_age = -1;
        int a;
        for (int i = 0; i < NV; i++)
            if (k < 0 && m_on[i] && m_note[i] == n) k = i;
        if (on) begin
            if (k >= 0) begin
                m_vel[k] = v; m_pend = 1;
                return;
            end
            for (int i = 0; i < NV; i++)
                if (k < 0 && !m_on[i]) k = i;
            if (k < 0) begin
`ifdef VOICE_STEAL_EN
                for (int i = 0; i < NV; i++) begin
                    a = m_allocs - m_stamp[i];
                    if (a > NV - 1) a = NV - 1;
                    if (a > best_age) begin best_age = a; k = i; end
                end
`else
                a = 0;
                best_age = a;
                exp_drop = 1; exp_drops++;
                return;
`endif
            end
            m_allocs++;
            m_stamp[k] = m_allocs;
            m_on[k] = 1; m_note[k] = n; m_vel[k] = v; m_pend = 1;
        end else if (k >= 0) begin
            m_on[k] = 0; m_note[k] = 0; m_vel[k] = 0; m_pend = 1;
        end
    endtask

    task automatic m_edge(input bit v, input logic [7:0] b);
        ecyc++;
        exp_chg = 0; exp_drop = 0;
        if (m_pend && ecyc - last_pub >= H) begin
            exp_data = snap_data(); exp_on = snap_on(); exp_chg = 1;
            last_pub = ecyc; m_pend = 0; exp_pulses++;
        end
        if (!v || b >= 8'hF8) return;
        if (b[7]) begin
            if ((b[7:4] == 4'h8 || b[7:4] == 4'h9) && int'(b[3:0]) == CH) begin
                m_is_on = (b[7:4] == 4'h9); ps = 1;
            end else begin
                ps = 3;
            end
        end else if (ps == 1) begin
            m_cur = int'(b); ps = 2;
        end else if (ps == 2) begin
            ps = 1;
            m_apply(m_is_on && b != 0, m_cur, int'(b));
        end
    endtask

    // One clock: drive, let the model take the same edge, compare every output.
    task automatic step(input bit v, input logic [7:0] b);
        logic [1:0] eps;
        @(negedge clk_in);
        midi_byte_valid_in = v;
        midi_byte_in = b;
        @(posedge clk_in);
        m_edge(v, b);
        #1;
        eps = 2'(ps);
        pulses += int'(midi_burst_change_out);
        drops  += int'(voice_drop_out);
        if ({midi_burst_change_out, voice_drop_out, parser_state_out} !== {exp_chg, exp_drop, eps}) begin
            if (mm == 0) begin
                mm_what = "chg/drop/state";
                mm_obs = 80'({midi_burst_change_out, voice_drop_out, parser_state_out});
                mm_exp = 80'({exp_chg, exp_drop, eps});
            end
            mm++;
        end else if (midi_burst_data_out !== exp_data || on_array_out !== exp_on) begin
            if (mm == 0) begin
                mm_what = "data/on";
                mm_obs = midi_burst_data_out ^ 80'(on_array_out);
                mm_exp = exp_data ^ 80'(exp_on);
            end
            mm++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in = 1'b0;
        midi_byte_valid_in = 1'b0;
        m_reset();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        m_reset();
        repeat (3) @(negedge clk_in);
        total++;
        if (midi_burst_data_out !== '0) $display("FAIL reset_data: got %h want 0", midi_burst_data_out); else passed++;
        total++;
        if (on_array_out !== '0) $display("FAIL reset_on: got %b want 0", on_array_out); else passed++;
        total++;
        if (midi_burst_change_out !== 1'b0) $display("FAIL reset_chg: got %b want 0", midi_burst_change_out); else passed++;
        total++;
        if (voice_drop_out !== 1'b0) $display("FAIL reset_drop: got %b want 0", voice_drop_out); else passed++;
        total++;
        if (parser_state_out !== 2'd0) $display("FAIL reset_state: got %0d want 0", parser_state_out); else passed++;
        rst_n_in = 1'b1;
        idle(5);
        total++;
        if (mm !== 0) $display("FAIL trace_reset: %0d bad cycles, %s got %h want %h", mm, mm_what, mm_obs, mm_exp); else passed++;
    endtask

    task automatic test_single();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        idle(80);
        total++;
        if (mm !== 0) $display("FAIL trace_single: %0d bad cycles, %s got %h want %h", mm, mm_what, mm_obs, mm_exp); else passed++;
        total++;
        if (pulses !== 1) $display("FAIL single_pulses: got %0d want 1", pulses); else passed++;
        total++;
        if (on_array_out !== 5'b00001) $display("FAIL single_on: got %b want 00001", on_array_out); else passed++;
        total++;
        if (midi_burst_data_out[15:0] !== 16'h3C64) $display("FAIL single_slot0: got %h want 3c64", midi_burst_data_out[15:0]); else passed++;
    endtask

    task automatic test_running();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h50);
        idle(80);
        total++;
        if (mm !== 0) $display("FAIL trace_running: %0d bad cycles, %s got %h want %h", mm, mm_what, mm_obs, mm_exp); else passed++;
        total++;
        if (on_array_out !== 5'b00011) $display("FAIL running_on: got %b want 00011", on_array_out); else passed++;
        total++;
        if (midi_burst_data_out[31:16] !== 16'h4050) $display("FAIL running_slot1: got %h want 4050", midi_burst_data_out[31:16]); else passed++;
        total++;
        if (pulses !== exp_pulses) $display("FAIL running_pulses: got %0d want %0d", pulses, exp_pulses); else passed++;
    endtask

    task automatic test_note_off();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        idle(70);
        send(8'h3C); send(8'h00);
        idle(70);
        total++;
        if (mm !== 0) $display("FAIL trace_note_off: %0d bad cycles, %s got %h want %h", mm, mm_what, mm_obs, mm_exp); else passed++;
        total++;
        if (pulses !== 2) $display("FAIL note_off_pulses: got %0d want 2", pulses); else passed++;
        total++;
        if (on_array_out !== 5'b00000) $display("FAIL note_off_on: got %b want 00000", on_array_out); else passed++;
        total++;
        if (midi_burst_data_out[15:0] !== 16'h0000) $display("FAIL note_off_slot0: got %h want 0000", midi_burst_data_out[15:0]); else passed++;
    endtask

    task automatic test_full();
        do_reset();
        send(8'h90);
        for (int n = 8'h3C; n <= 8'h41; n++) begin
            send(8'(n)); send(8'h40);
        end
        idle(80);
        total++;
        if (mm !== 0) $display("FAIL trace_full: %0d bad cycles, %s got %h want %h", mm, mm_what, mm_obs, mm_exp); else passed++;
        total++;
        if (on_array_out !== 5'b11111) $display("FAIL full_on: got %b want 11111", on_array_out); else passed++;
`ifdef VOICE_STEAL_EN
        total++;
        if (drops !== 0) $display("FAIL full_drops: got %0d want 0", drops); else passed++;
        total++;
        if (midi_burst_data_out[15:8] !== 8'h41) $display("FAIL full_steal_slot0: got %h want 41", midi_burst_data_out[15:8]); else passed++;
`else
        total++;
        if (drops !== 1) $display("FAIL full_drops: got %0d want 1", drops); else passed++;
        total++;
        if (midi_burst_data_out[15:0] !== 16'h3C40) $display("FAIL full_slot0: got %h want 3c40", midi_burst_data_out[15:0]); else passed++;
`endif
    endtask

    task automatic test_filter();
        do_reset();
        send(8'h91); send(8'h3C); send(8'h64);
        send(8'h90); send(8'hF8); send(8'h3C); send(8'h64);
        send(8'hB0); send(8'h07); send(8'h7F);
        idle(80);
        total++;
        if (mm !== 0) $display("FAIL trace_filter: %0d bad cycles, %s got %h want %h", mm, mm_what, mm_obs, mm_exp); else passed++;
        total++;
        if (on_array_out !== 5'b00001) $display("FAIL filter_on: got %b want 00001", on_array_out); else passed++;
        total++;
        if (midi_burst_data_out !== 80'h3C64) $display("FAIL filter_data: got %h want 3c64", midi_burst_data_out); else passed++;
        total++;
        if (pulses !== 1) $display("FAIL filter_pulses: got %0d want 1", pulses); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h90); send(8'h3C); send(8'h64);
        idle(5);
        send(8'h45);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        midi_byte_valid_in = 1'b0;
        #1;
        total++;
        if ({midi_burst_data_out, on_array_out, parser_state_out} !== '0)
            $display("FAIL reset_mid_async: got %h/%b/%0d want all 0", midi_burst_data_out, on_array_out, parser_state_out);
        else passed++;
        m_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        send(8'h64);
        idle(80);
        total++;
        if (mm !== 0) $display("FAIL trace_reset_mid: %0d bad cycles, %s got %h want %h", mm, mm_what, mm_obs, mm_exp); else passed++;
        total++;
        if (on_array_out !== '0 || pulses !== 0) $display("FAIL reset_mid_after: on %b pulses %0d want 0/0", on_array_out, pulses); else passed++;
    endtask

    task automatic test_random();
        int k;
        logic [7:0] b;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            k = $urandom_range(0, 39);
            if (k < 20) begin
                case (k)
                    0, 1:    b = 8'h90;
                    2:       b = 8'h80;
                    3:       b = 8'h91;
                    4:       b = 8'hB0;
                    5:       b = 8'hF8;
                    6:       b = 8'hFE;
                    7:       b = 8'hF0;
                    8, 9, 10, 11, 12, 13: b = 8'h3C + 8'($urandom_range(0, 7));
                    default: b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
                endcase
                send(b);
            end else if (k == 39) begin
                idle($urandom_range(20, 90));
            end else begin
                idle(1);
            end
        end
        idle(80);
        total++;
        if (mm !== 0) $display("FAIL trace_random: %0d bad cycles, %s got %h want %h", mm, mm_what, mm_obs, mm_exp); else passed++;
        total++;
        if (pulses !== exp_pulses) $display("FAIL random_pulses: got %0d want %0d", pulses, exp_pulses); else passed++;
        total++;
        if (drops !== exp_drops) $display("FAIL random_drops: got %0d want %0d", drops, exp_drops); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_running();
        test_note_off();
        test_full();
        test_filter();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
